imem_ctrl: RTL and testbench



---
 rtl/imem_pkg.sv | 22 ++
 rtl/imem_ram.sv | 27 ++
 rtl/imem_ctrl.sv | 163 ++++++++++++++++
 tb/tb_imem_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: FSM state type, default fill word and the byte-to-word index helper
// shared by the instruction memory controller and its storage array.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_LOAD
  } state_e;

  localparam logic [31:0] NOP_WORD   = 32'h0000_0013;
  localparam int          MAX_ADDR_W = 64;

  // Word index of a byte address: drop the byte offset, keep idx_w bits.
  function automatic logic [MAX_ADDR_W-1:0] word_idx(input logic [MAX_ADDR_W-1:0] addr,
                                                     input int unsigned          idx_w);
    logic [MAX_ADDR_W-1:0] mask;
    mask = (MAX_ADDR_W'(1) << idx_w) - MAX_ADDR_W'(1);
    return (addr >> 2) & mask;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// imem_ram: single-port storage array, synchronous write and registered read.
module imem_ram #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 64,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [IDX_W-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem_q[addr] <= wdata;
      else    rdata_q     <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imem_ctrl.sv
// imem_ctrl: instruction memory with self-clear, req/valid fetch port and burst
// program-load port. Define IMEM_PARITY_EN to add per-word even parity checking.
module imem_ctrl
  import imem_pkg::*;
#(
  parameter int                 DATA_W    = 32,
  parameter int                 DEPTH     = 64,
  parameter int                 ADDR_W    = 32,
  parameter logic [DATA_W-1:0]  FILL_WORD = DATA_W'(NOP_WORD)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_err,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_wrap,
`ifdef IMEM_PARITY_EN
  input  logic              parity_inject,
`endif
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
  localparam int RAM_W = DATA_W + 1;
`else
  localparam int RAM_W = DATA_W;
`endif

  state_e           state_q, state_d;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             wrap_q, wrap_d;
  logic             valid_q, valid_d;
  logic             rng_err_q, rng_err_d;

  logic             ram_en, ram_we;
  logic [IDX_W-1:0] ram_addr;
  logic [DATA_W-1:0] wr_word;
  logic             inv_par;
  logic [RAM_W-1:0] ram_wdata, ram_rdata;

  logic [IDX_W-1:0] fetch_idx, base_idx;
  logic             fetch_bad;

  assign fetch_idx = IDX_W'(word_idx(MAX_ADDR_W'(fetch_addr), IDX_W));
  assign base_idx  = IDX_W'(word_idx(MAX_ADDR_W'(load_base), IDX_W));
  assign fetch_bad = (fetch_addr[1:0] != 2'b00) || ((fetch_addr >> (IDX_W + 2)) != '0);

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    wrap_d    = wrap_q;
    valid_d   = 1'b0;
    rng_err_d = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = fetch_idx;
    wr_word   = load_data;
    inv_par   = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = clr_cnt_q;
        wr_word   = FILL_WORD;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == IDX_W'(DEPTH - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        // A fetch and a load_start may be taken in the same cycle: the read
        // completes at this edge, before any load beat can write.
        if (fetch_req) begin
          ram_en    = 1'b1;
          valid_d   = 1'b1;
          rng_err_d = fetch_bad;
        end
        if (load_start) begin
          state_d  = ST_LOAD;
          wr_ptr_d = base_idx;
          wrap_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (load_valid) begin
          ram_en   = 1'b1;
          ram_we   = 1'b1;
          ram_addr = wr_ptr_q;
`ifdef IMEM_PARITY_EN
          inv_par  = parity_inject;
`endif
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_ptr_q == IDX_W'(DEPTH - 1)) wrap_d = 1'b1;
          if (load_last) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

`ifdef IMEM_PARITY_EN
  assign ram_wdata = {(^wr_word) ^ inv_par, wr_word};
`else
  assign ram_wdata = wr_word;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      wr_ptr_q  <= '0;
      wrap_q    <= 1'b0;
      valid_q   <= 1'b0;
      rng_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      wrap_q    <= wrap_d;
      valid_q   <= valid_d;
      rng_err_q <= rng_err_d;
    end
  end

  imem_ram #(
    .WIDTH (RAM_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en & ~reset),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  logic par_err;
`ifdef IMEM_PARITY_EN
  assign par_err = valid_q && ((^ram_rdata[DATA_W-1:0]) != ram_rdata[DATA_W]);
`else
  assign par_err = 1'b0;
`endif

  assign fetch_ready = (state_q == ST_IDLE);
  assign load_ready  = (state_q == ST_LOAD);
  assign busy        = (state_q == ST_CLEAR) || (state_q == ST_LOAD);
  assign load_wrap   = wrap_q;
  assign fetch_valid = valid_q;
  assign fetch_err   = (valid_q && rng_err_q) || par_err;
  // Range/alignment errors mask the data; a parity error passes it through.
  assign fetch_data  = (valid_q && !rng_err_q) ? ram_rdata[DATA_W-1:0] : '0;

endmodule

// File: tb/tb_imem_ctrl.sv
// tb_imem_ctrl: directed table, multi-cycle corner sequences and randomized
// load/fetch traffic checked against a word-array model of the memory.
`timescale 1ns/1ps
module tb_imem_ctrl;

  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 64;
  localparam int          ADDR_W = 32;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              fetch_req = 1'b0;
  logic [ADDR_W-1:0] fetch_addr = '0;
  logic              fetch_ready, fetch_valid, fetch_err;
  logic [DATA_W-1:0] fetch_data;
  logic              load_start = 1'b0;
  logic [ADDR_W-1:0] load_base = '0;
  logic              load_valid = 1'b0;
  logic [DATA_W-1:0] load_data = '0;
  logic              load_last = 1'b0;
  logic              load_ready, load_wrap, busy;
`ifdef IMEM_PARITY_EN
  logic              parity_inject = 1'b0;
`endif

  always #5 clk = ~clk;

  imem_ctrl #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .fetch_err   (fetch_err),
    .load_start  (load_start),
    .load_base   (load_base),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .load_wrap   (load_wrap),
`ifdef IMEM_PARITY_EN
    .parity_inject (parity_inject),
`endif
    .busy        (busy)
  );

  // Reference model: plain word array plus the sticky wrap flag.
  logic [31:0] model_mem [DEPTH];
  logic        model_wrap;
  logic [32:0] exp_q[$];
  logic [31:0] fq[$];
  logic [31:0] lq[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } fvec_t;
  fvec_t tbl[7];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [32:0] model_fetch(input logic [31:0] a);
    if ((a % 4) != 0 || a >= 32'(DEPTH * 4)) return {1'b1, 32'h0};
    return {1'b0, model_mem[a / 4]};
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    while (!fetch_ready && n < 300) begin
      tick();
      n++;
    end
    check1(name, fetch_ready, 1'b1);
  endtask

  // Applies reset for one edge with whatever inputs are currently driven.
  task automatic do_reset();
    int cnt = 0;
    reset = 1'b1;
    tick();
    fetch_req = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    check1("rst_busy", busy, 1'b1);
    check1("rst_fetch_ready", fetch_ready, 1'b0);
    check1("rst_load_ready", load_ready, 1'b0);
    check1("rst_fetch_valid", fetch_valid, 1'b0);
    check1("rst_fetch_err", fetch_err, 1'b0);
    check32("rst_fetch_data", fetch_data, 32'h0);
    check1("rst_load_wrap", load_wrap, 1'b0);
    reset = 1'b0;
    while (busy && cnt < 300) begin
      check1("clear_no_ready", fetch_ready | load_ready, 1'b0);
      tick();
      cnt++;
    end
    check32("clear_cycles", 32'(cnt), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;
    model_wrap = 1'b0;
  endtask

  task automatic check_fetch(input string name);
    logic [32:0] e;
    e = exp_q.pop_front();
    check1({name, "_valid"}, fetch_valid, 1'b1);
    check1({name, "_err"}, fetch_err, e[32]);
    check32({name, "_data"}, fetch_data, e[31:0]);
  endtask

  // Issues every address in fq on consecutive cycles.
  task automatic run_fetches(input string name);
    wait_idle({name, "_idle"});
    for (int i = 0; i < fq.size(); i++) begin
      fetch_req  = 1'b1;
      fetch_addr = fq[i];
      exp_q.push_back(model_fetch(fq[i]));
      tick();
      check_fetch(name);
    end
    fetch_req = 1'b0;
    fq.delete();
    tick();
    check1({name, "_valid_drop"}, fetch_valid, 1'b0);
  endtask

  // Loads the words in lq starting at byte address base.
  task automatic do_load(input logic [31:0] base, input bit gaps);
    int ptr;
    wait_idle("load_idle");
    load_start = 1'b1;
    load_base  = base;
    tick();
    load_start = 1'b0;
    check1("load_wrap_clr", load_wrap, 1'b0);
    check1("load_ready", load_ready, 1'b1);
    model_wrap = 1'b0;
    ptr = int'((base / 4) % DEPTH);
    for (int i = 0; i < lq.size(); i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        load_valid = 1'b0;
        tick();
      end
      load_valid = 1'b1;
      load_data  = lq[i];
      load_last  = (i == lq.size() - 1);
      tick();
      model_mem[ptr] = lq[i];
      if (ptr == DEPTH - 1) model_wrap = 1'b1;
      ptr = (ptr + 1) % DEPTH;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    lq.delete();
    check1("load_wrap", load_wrap, model_wrap);
    check1("load_done_busy", busy, 1'b0);
  endtask

  initial begin
    tbl[0] = '{32'h10,  32'h0010_8093, 1'b0};
    tbl[1] = '{32'h14,  32'h0011_0113, 1'b0};
    tbl[2] = '{32'h18,  32'h0020_8133, 1'b0};
    tbl[3] = '{32'h102, 32'h0,         1'b1};
    tbl[4] = '{32'h100, 32'h0,         1'b1};
    tbl[5] = '{32'h00,  NOP,           1'b0};
    tbl[6] = '{32'h7C,  NOP,           1'b0};

    do_reset();

    fq = '{32'h00, 32'h7C};
    run_fetches("post_clear");

    lq = '{32'h0010_8093, 32'h0011_0113, 32'h0020_8133};
    do_load(32'h10, 1'b0);

    // Back-to-back table fetches with fixed expectations.
    wait_idle("tbl_idle");
    for (int i = 0; i < 7; i++) begin
      fetch_req  = 1'b1;
      fetch_addr = tbl[i].addr;
      tick();
      check1("tbl_valid", fetch_valid, 1'b1);
      check1("tbl_err", fetch_err, tbl[i].err);
      check32("tbl_data", fetch_data, tbl[i].data);
    end
    fetch_req = 1'b0;
    tick();

    // Simultaneous fetch and load_start: old contents returned, then LOAD.
    wait_idle("sim_idle");
    fetch_req = 1'b1; fetch_addr = 32'h10;
    load_start = 1'b1; load_base = 32'h10;
    tick();
    fetch_req = 1'b0;
    load_start = 1'b1; load_base = 32'h80;  // ignored while loading
    check1("sim_valid", fetch_valid, 1'b1);
    check32("sim_data", fetch_data, 32'h0010_8093);
    check1("sim_load_ready", load_ready, 1'b1);
    load_valid = 1'b1; load_data = 32'hCAFE_0001; load_last = 1'b1;
    tick();
    load_valid = 1'b0; load_last = 1'b0; load_start = 1'b0;
    model_mem[4] = 32'hCAFE_0001;
    fq = '{32'h10, 32'h80};
    run_fetches("sim_after");

    // Wrap past the last word, then the next load_start clears the flag.
    lq = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    do_load(32'hF8, 1'b0);
    check1("wrap_set", load_wrap, 1'b1);
    fq = '{32'hF8, 32'hFC, 32'h00};
    run_fetches("wrap_rd");
    lq = '{32'h1234_5678};
    do_load(32'h40, 1'b0);

`ifdef IMEM_PARITY_EN
    parity_inject = 1'b1;
    lq = '{32'hDEAD_BEEF};
    do_load(32'h20, 1'b0);
    parity_inject = 1'b0;
    wait_idle("par_idle");
    fetch_req = 1'b1; fetch_addr = 32'h20;
    tick();
    fetch_req = 1'b0;
    check1("par_err", fetch_err, 1'b1);
    check32("par_data", fetch_data, 32'hDEAD_BEEF);
    lq = '{32'hDEAD_BEEF};
    do_load(32'h20, 1'b0);
    fq = '{32'h20};
    run_fetches("par_fixed");
`endif

    // Randomized loads and fetches against the model.
    for (int r = 0; r < 20; r++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) lq.push_back($urandom);
      do_load($urandom_range(0, 1023), 1'b1);
      for (int i = 0; i < 8; i++) begin
        int k;
        k = $urandom_range(0, 9);
        if (k < 7)       fq.push_back($urandom_range(0, DEPTH - 1) * 4);
        else if (k == 7) fq.push_back($urandom_range(0, 255) | 1);
        else             fq.push_back($urandom_range(256, 4095));
      end
      run_fetches("rnd");
    end

    // Reset on the second beat of a burst that has already wrapped.
    wait_idle("mid_idle");
    load_start = 1'b1; load_base = 32'hFC;
    tick();
    load_start = 1'b0;
    load_valid = 1'b1; load_data = 32'h5555_AAAA; load_last = 1'b0;
    tick();
    check1("mid_wrap", load_wrap, 1'b1);
    load_data = 32'h6666_BBBB;
    do_reset();
    check1("mid_wrap_cleared", load_wrap, 1'b0);
    for (int i = 0; i < DEPTH; i++) fq.push_back(32'(i * 4));
    run_fetches("mid_rd");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
